// File: rtl/float_pkg.sv
// Shared float32 definitions for the float/integer conversion blocks.
package float_pkg;

  localparam int          F32_EXP_BIAS = 127;
  localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN    = 32'h8000_0000;

  localparam int FLAG_NV = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } round_mode_e;

  // CLS_ZERO covers both zero and denormal encodings (E == 0).
  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } f32_class_e;

  typedef struct packed {
    logic              sign;
    logic signed [8:0] exp;
    logic [22:0]       frac;
    f32_class_e        cls;
  } f32_unpacked_t;

  function automatic f32_unpacked_t unpack_f32(input logic [31:0] w);
    f32_unpacked_t u;
    u.sign = w[31];
    u.exp  = $signed({1'b0, w[30:23]}) - 9'(F32_EXP_BIAS);
    u.frac = w[22:0];
    if (w[30:23] == 8'hFF) begin
      u.cls = (w[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (w[30:23] == 8'h00) begin
      u.cls = CLS_ZERO;
    end else begin
      u.cls = CLS_NORMAL;
    end
    return u;
  endfunction

endpackage

// File: rtl/float_to_int_round.sv
// Combinational second stage: shift, guard/sticky, RNE increment,
// negate and saturate an unpacked float32 into a signed int32.
module float_to_int_round
  import float_pkg::*;
#(
  parameter logic [31:0] P_NAN_RESULT = 32'h0000_0000
) (
  input  f32_unpacked_t op_i,
  input  round_mode_e   mode_i,
  output logic [31:0]   result_o,
  output logic [1:0]    flag_o
);

  logic signed [8:0] e;
  logic [23:0]       mant;
  logic [4:0]        rshAmt;
  logic [2:0]        lshAmt;
  logic [47:0]       ext;
  logic [31:0]       mag;
  logic [31:0]       magR;
  logic              guard;
  logic              sticky;
  logic              incr;

  always_comb begin
    e        = op_i.exp;
    mant     = {1'b1, op_i.frac};
    rshAmt   = 5'(9'sd23 - e);
    lshAmt   = 3'(e - 9'sd23);
    // Upper 24 bits hold the integer part, bit 23 the guard, the rest sticky.
    ext      = {mant, 24'd0} >> rshAmt;
    mag      = 32'd0;
    magR     = 32'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    incr     = 1'b0;
    result_o = 32'd0;
    flag_o   = 2'b00;

    case (op_i.cls)
      CLS_NAN: begin
        result_o        = P_NAN_RESULT;
        flag_o[FLAG_NV] = 1'b1;
      end
      CLS_INF: begin
        result_o        = op_i.sign ? INT32_MIN : INT32_MAX;
        flag_o[FLAG_NV] = 1'b1;
      end
      CLS_ZERO: begin
        flag_o[FLAG_NX] = (op_i.frac != 23'd0);
      end
      default: begin
        if (e >= 9'sd31) begin
          // -2^31 is the one value at e=31 that is representable.
          if (op_i.sign && (e == 9'sd31) && (op_i.frac == 23'd0)) begin
            result_o = INT32_MIN;
          end else begin
            result_o        = op_i.sign ? INT32_MIN : INT32_MAX;
            flag_o[FLAG_NV] = 1'b1;
          end
        end else begin
          if (e >= 9'sd23) begin
            mag = {8'd0, mant} << lshAmt;
          end else if (e >= 9'sd0) begin
            mag    = {8'd0, ext[47:24]};
            guard  = ext[23];
            sticky = |ext[22:0];
          end else begin
            guard  = (e == -9'sd1);
            sticky = (e == -9'sd1) ? (op_i.frac != 23'd0) : 1'b1;
          end
          incr            = (mode_i == RND_RNE) && guard && (sticky || mag[0]);
          magR            = mag + 32'(incr);
          result_o        = op_i.sign ? (~magR + 32'd1) : magR;
          flag_o[FLAG_NX] = guard | sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/float_to_int.sv
// Two-stage float32 -> int32 converter with REQ/BUSY input and
// VALID/BUSY output handshakes.
module float_to_int
  import float_pkg::*;
#(
  parameter logic [31:0] P_NAN_RESULT = 32'h0000_0000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iDATA_REQ,
  output logic        oDATA_BUSY,
  input  logic [31:0] iDATA,
  input  logic        iROUND,
  output logic        oDATA_VALID,
  input  logic        iDATA_BUSY,
  output logic [31:0] oDATA,
  output logic [1:0]  oDATA_FLAG
);

  logic          s1Valid_q, s1Valid_d;
  f32_unpacked_t s1Op_q, s1Op_d;
  round_mode_e   s1Mode_q, s1Mode_d;
  logic          s2Valid_q, s2Valid_d;
  logic [31:0]   s2Data_q, s2Data_d;
  logic [1:0]    s2Flag_q, s2Flag_d;

  logic          s1Adv;
  logic          s2Adv;
  logic [31:0]   rndData;
  logic [1:0]    rndFlag;

  float_to_int_round #(
    .P_NAN_RESULT(P_NAN_RESULT)
  ) u_round (
    .op_i    (s1Op_q),
    .mode_i  (s1Mode_q),
    .result_o(rndData),
    .flag_o  (rndFlag)
  );

  // An empty stage always accepts, so bubbles collapse under backpressure.
  assign s2Adv      = !s2Valid_q || !iDATA_BUSY;
  assign s1Adv      = !s1Valid_q || s2Adv;
  assign oDATA_BUSY = !s1Adv;

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Op_d    = s1Op_q;
    s1Mode_d  = s1Mode_q;
    s2Valid_d = s2Valid_q;
    s2Data_d  = s2Data_q;
    s2Flag_d  = s2Flag_q;

    if (s1Adv) begin
      s1Valid_d = iDATA_REQ;
      if (iDATA_REQ) begin
        s1Op_d   = unpack_f32(iDATA);
        s1Mode_d = round_mode_e'(iROUND);
      end
    end

    if (s2Adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Data_d = rndData;
        s2Flag_d = rndFlag;
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= '0;
      s1Mode_q  <= RND_TRUNC;
      s2Valid_q <= 1'b0;
      s2Data_q  <= 32'd0;
      s2Flag_q  <= 2'b00;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Op_q    <= s1Op_d;
      s1Mode_q  <= s1Mode_d;
      s2Valid_q <= s2Valid_d;
      s2Data_q  <= s2Data_d;
      s2Flag_q  <= s2Flag_d;
    end
  end

  assign oDATA_VALID = s2Valid_q;
  assign oDATA       = s2Data_q;
  assign oDATA_FLAG  = s2Flag_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed-vector bench for float_to_int: conversions, specials,
// backpressure drain and mid-flight reset.
module tb_float_to_int;

  localparam logic [31:0] NAN_RES = 32'h5A5A_5A5A;

  logic        iCLOCK      = 1'b0;
  logic        inRESET     = 1'b0;
  logic        iDATA_REQ   = 1'b0;
  logic [31:0] iDATA       = 32'd0;
  logic        iROUND      = 1'b0;
  logic        iDATA_BUSY  = 1'b0;
  logic        oDATA_BUSY;
  logic        oDATA_VALID;
  logic [31:0] oDATA;
  logic [1:0]  oDATA_FLAG;

  int nChecks = 0;
  int nFail   = 0;
  int inIdx   = 0;
  int outIdx  = 0;

  logic [31:0] bpWord [6] = '{32'h4228_0000, 32'hC194_4800, 32'h3FC0_0000,
                              32'h4EFF_FFFF, 32'h0000_0000, 32'h4020_0000};
  logic [31:0] bpExpD [6] = '{32'h0000_002A, 32'hFFFF_FFEE, 32'h0000_0001,
                              32'h7FFF_FF80, 32'h0000_0000, 32'h0000_0002};
  logic [1:0]  bpExpF [6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};

  float_to_int #(
    .P_NAN_RESULT(NAN_RES)
  ) dut (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .iDATA_REQ  (iDATA_REQ),
    .oDATA_BUSY (oDATA_BUSY),
    .iDATA      (iDATA),
    .iROUND     (iROUND),
    .oDATA_VALID(oDATA_VALID),
    .iDATA_BUSY (iDATA_BUSY),
    .oDATA      (oDATA),
    .oDATA_FLAG (oDATA_FLAG)
  );

  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expD, input logic [1:0] expF);
    check({tag, "_valid"}, 32'(oDATA_VALID), 32'd1);
    check({tag, "_data"},  oDATA, expD);
    check({tag, "_flag"},  32'(oDATA_FLAG), 32'(expF));
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic r);
    @(negedge iCLOCK);
    iDATA     = d;
    iROUND    = r;
    iDATA_REQ = 1'b1;
    @(negedge iCLOCK);
    iDATA_REQ = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [31:0] d, input logic r,
                         input logic [31:0] expD, input logic [1:0] expF);
    applyStimulus(d, r);
    check({tag, "_lat"}, 32'(oDATA_VALID), 32'd0);
    @(negedge iCLOCK);
    checkOutput(tag, expD, expF);
  endtask

  initial begin
    $display("[TB] start");
    inRESET = 1'b0;
    repeat (2) @(negedge iCLOCK);
    check("rst_valid", 32'(oDATA_VALID), 32'd0);
    check("rst_data",  oDATA, 32'd0);
    check("rst_flag",  32'(oDATA_FLAG), 32'd0);
    check("rst_busy",  32'(oDATA_BUSY), 32'd0);
    inRESET = 1'b1;

    convert("trunc_14071",  32'h465B_DF90, 1'b0, 32'h0000_36F7, 2'b01);
    convert("rne_14071",    32'h465B_DF90, 1'b1, 32'h0000_36F8, 2'b01);
    convert("trunc_m18",    32'hC194_4800, 1'b0, 32'hFFFF_FFEE, 2'b01);
    convert("rne_m18",      32'hC194_4800, 1'b1, 32'hFFFF_FFED, 2'b01);
    convert("rne_small",    32'h3CC8_0000, 1'b1, 32'h0000_0000, 2'b01);
    convert("rne_half",     32'h3F00_0000, 1'b1, 32'h0000_0000, 2'b01);
    convert("rne_0p75",     32'h3F40_0000, 1'b1, 32'h0000_0001, 2'b01);
    convert("rne_1p5",      32'h3FC0_0000, 1'b1, 32'h0000_0002, 2'b01);
    convert("rne_2p5",      32'h4020_0000, 1'b1, 32'h0000_0002, 2'b01);
    convert("rne_3p5",      32'h4060_0000, 1'b1, 32'h0000_0004, 2'b01);
    convert("exact_42",     32'h4228_0000, 1'b1, 32'h0000_002A, 2'b00);
    convert("exact_e30",    32'h4EFF_FFFF, 1'b0, 32'h7FFF_FF80, 2'b00);
    convert("pos_inf",      32'h7F80_0000, 1'b0, 32'h7FFF_FFFF, 2'b10);
    convert("neg_inf",      32'hFF80_0000, 1'b1, 32'h8000_0000, 2'b10);
    convert("nan",          32'h7FC0_0000, 1'b1, NAN_RES,       2'b10);
    convert("pos_2p31",     32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, 2'b10);
    convert("neg_2p31",     32'hCF00_0000, 1'b0, 32'h8000_0000, 2'b00);
    convert("neg_2p31_ov",  32'hCF00_0001, 1'b0, 32'h8000_0000, 2'b10);
    convert("denorm",       32'h0000_0001, 1'b1, 32'h0000_0000, 2'b01);
    convert("neg_zero",     32'h8000_0000, 1'b1, 32'h0000_0000, 2'b00);

    // Backpressure: six words offered back to back, output stalled 5 cycles.
    inIdx  = 0;
    outIdx = 0;
    for (int cyc = 0; cyc < 40 && outIdx < 6; cyc++) begin
      @(negedge iCLOCK);
      iDATA_BUSY = (cyc < 5);
      #1;
      if (cyc < 5) check($sformatf("bp_busy%0d", cyc), 32'(oDATA_BUSY), 32'(cyc >= 2));
      if (cyc >= 5) check($sformatf("bp_drain%0d", cyc), 32'(oDATA_VALID), 32'd1);
      if (oDATA_VALID) begin
        check($sformatf("bp_data%0d", outIdx), oDATA, bpExpD[outIdx]);
        check($sformatf("bp_flag%0d", outIdx), 32'(oDATA_FLAG), 32'(bpExpF[outIdx]));
        if (!iDATA_BUSY) outIdx++;
      end
      if (inIdx < 6) begin
        iDATA     = bpWord[inIdx];
        iROUND    = 1'b0;
        iDATA_REQ = 1'b1;
        if (!oDATA_BUSY) inIdx++;
      end else begin
        iDATA_REQ = 1'b0;
      end
    end
    iDATA_REQ  = 1'b0;
    iDATA_BUSY = 1'b0;
    check("bp_in_count",  32'(inIdx),  32'd6);
    check("bp_out_count", 32'(outIdx), 32'd6);
    @(negedge iCLOCK);
    check("bp_nodup", 32'(oDATA_VALID), 32'd0);

    // Reset with two words in flight and the output stalled.
    @(negedge iCLOCK);
    iDATA     = 32'h4228_0000;
    iROUND    = 1'b0;
    iDATA_REQ = 1'b1;
    @(negedge iCLOCK);
    iDATA     = 32'h3FC0_0000;
    @(negedge iCLOCK);
    iDATA_REQ  = 1'b0;
    iDATA_BUSY = 1'b1;
    inRESET    = 1'b0;
    @(negedge iCLOCK);
    inRESET    = 1'b1;
    iDATA_BUSY = 1'b0;
    #1;
    check("mrst_valid", 32'(oDATA_VALID), 32'd0);
    check("mrst_busy",  32'(oDATA_BUSY),  32'd0);
    check("mrst_data",  oDATA, 32'd0);
    check("mrst_flag",  32'(oDATA_FLAG), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLOCK);
      check($sformatf("mrst_stale%0d", k), 32'(oDATA_VALID), 32'd0);
    end

    convert("post_rst", 32'h40200000, 1'b0, 32'h0000_0002, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Downstream consumer of mul_float: converts an IEEE-754 single-precision result stream into signed 32-bit integers.
- Two-stage pipeline. Accepts the same REQ/BUSY input handshake that mul_float drives on its output, and presents a VALID/BUSY output handshake to the next integer stage.
- Supports truncate and round-to-nearest-even modes, reports invalid/inexact flags, and saturates out-of-range values.

Parameters:
- P_NAN_RESULT, 32'h00000000, integer result returned for NaN inputs.

Ports:
- iCLOCK  in  1  clock, rising edge.
- inRESET  in  1  reset; one clock, synchronous, active-low.
- iDATA_REQ  in  1  input word valid.
- oDATA_BUSY  out  1  input cannot be accepted this cycle.
- iDATA  in  32  float32 operand.
- iROUND  in  1  0 = truncate toward zero, 1 = round-nearest-even; sampled with iDATA.
- oDATA_VALID  out  1  result valid.
- iDATA_BUSY  in  1  downstream stall.
- oDATA  out  32  signed int32 result.
- oDATA_FLAG  out  2  {NV invalid, NX inexact}, aligned with oDATA.

Behaviour:
- Reset: synchronous on iCLOCK when inRESET=0. Clears both stage valids. oDATA_VALID=0, oDATA=0, oDATA_FLAG=0. oDATA_BUSY=0 while the pipeline is empty.
- Reset mid-operation discards in-flight words. No output follows for them.
- Input transfer: iDATA_REQ && !oDATA_BUSY at a rising edge. Output transfer: oDATA_VALID && !iDATA_BUSY.
- Stage 1 (unpack): registers sign, e = E-127, significand m = {1,frac}, NaN/Inf/zero/denormal class, and the round mode.
- Stage 2 (shift/round/negate/saturate): output register. Drives oDATA, oDATA_FLAG and oDATA_VALID.
- Latency: 2 cycles from input transfer to oDATA_VALID when not stalled. Throughput: 1 word/cycle.
- Advance rules:
  - s2_adv = !s2_valid || !iDATA_BUSY.
  - s1_adv = !s1_valid || s2_adv.
  - oDATA_BUSY = !s1_adv (combinational; no dependency on iDATA_REQ).
  - Bubbles collapse: an empty stage 2 accepts from stage 1 even while iDATA_BUSY=1.
- While oDATA_VALID && iDATA_BUSY, oDATA and oDATA_FLAG are held stable.
- Simultaneous output transfer and stage-1 refill in one cycle is required; no lost or duplicated words.
- Conversion rules:
  - E=255, frac≠0 (NaN): P_NAN_RESULT, NV=1, NX=0.
  - E=255, frac=0 (±Inf): +Inf → 32'h7FFFFFFF, −Inf → 32'h80000000, NV=1.
  - E=0 (zero/denormal): result 0. NX = (frac≠0). Denormals are not rounded up, even in RNE.
  - e≥31: saturate as for Inf, NV=1. Exception: negative, e=31, frac=0 → 32'h80000000 with no flags.
  - 23≤e≤30: magnitude = m<<(e−23), exact, NX=0.
  - 0≤e≤22: magnitude = m>>(23−e). Guard = next bit; sticky = OR of the remaining bits. NX = guard|sticky. RNE increments when guard && (sticky || lsb).
  - e<0: truncated magnitude 0, NX=1. RNE yields 1 only when e=−1 and frac≠0. Exactly 0.5 rounds to 0.
  - Sign applied by two's-complement negation after rounding. Rounding never overflows int32 (e≤30 ⇒ magnitude<2^31).
  - NV and NX are never both 1.

Decomposition:
- float_pkg holds:
  - F32_EXP_BIAS=127.
  - INT32_MAX/INT32_MIN.
  - round-mode enum (RND_TRUNC, RND_RNE).
  - flag bit indices (FLAG_NV=1, FLAG_NX=0).
  - typedef struct for unpacked float32 (sign, exp, frac, class).
- mul_float shares float_pkg when it is next touched.
- One natural sub-module: float_to_int_round. It is combinational stage-2 logic: shift, guard/sticky, RNE increment, negate, saturate. The stage register and handshake stay in float_to_int.

Test Plan:
- 32'h465bdf90 (14071.890625), trunc then RNE → 32'h000036F7 NX=1; 32'h000036F8 NX=1. Each result appears 2 cycles after acceptance.
- 32'hc1944800 (−18.535), trunc/RNE → 32'hFFFFFFEE / 32'hFFFFFFED, NX=1. 32'h3cc80000 → 0, NX=1.
- RNE ties: 32'h3f000000 (0.5) → 0; 32'h3fc00000 (1.5) → 2; 32'h40200000 (2.5) → 2. All NX=1.
- Specials:
  - 32'h7f800000 → 32'h7FFFFFFF NV.
  - 32'hff800000 → 32'h80000000 NV.
  - 32'h7fc00000 → P_NAN_RESULT NV.
  - 32'h4f000000 → 32'h7FFFFFFF NV.
  - 32'hcf000000 → 32'h80000000, no flags.
  - 32'h00000001 → 0 NX.
- Backpressure: 6 back-to-back requests with iDATA_BUSY=1 for 5 cycles. oDATA_BUSY asserts after the 3rd word is held. On release, results drain in order, one per cycle, oDATA stable while stalled, no loss or duplication.
- Reset: inRESET low for 1 cycle with 2 words in flight. The following cycle oDATA_VALID=0 and oDATA_BUSY=0, and no stale output ever appears.
